// File: rtl/lc3_sequencer.sv
// lc3_sequencer: multi-cycle control sequencer for an LC-3 style datapath.
//
// Walks each instruction through fetch (F_ADDR, F_MEM, F_IR) and DECODE, then
// one of: EXEC (ALU ops), M_ADDR/M_MEM/M_WB (LD/ST) or BRANCH, and back to
// F_ADDR. Memory waits are bounded by WAIT_MAX cycles; on expiry the access is
// abandoned with a MEM_ERR pulse.
//
// Parameters
//   WAIT_MAX      max cycles to wait for MEM_RDY before aborting (default 15)
// Optional feature
//   LC3_MUL_SHIFT_EN  when defined, opcode 1011 decodes to MUL/SL/SR;
//                     when undefined, opcode 1011 is illegal.
// Ports
//   CLK, RST_N            clock, synchronous active-low reset
//   IR[15:0], NZP[2:0]    instruction register and condition codes
//   MEM_RDY               memory access complete this cycle
//   MAR_LE .. REG_WE      one-cycle datapath load enables
//   MAR_SEL, PC_SEL       MAR source (1 = effective address), PC source (1 = branch)
//   ALU_CONTROL, IS_IMMEDIATE  ALU opcode and immediate B-operand select (EXEC only)
//   MEM_REQ, MEM_WE       memory request and write qualifier
//   ILLEGAL_OP, MEM_ERR   registered one-cycle error pulses
module lc3_sequencer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] IR,
  input  logic [2:0]  NZP,
  input  logic        MEM_RDY,
  output logic        MAR_LE,
  output logic        MDR_LE,
  output logic        PC_LE,
  output logic        IR_LE,
  output logic        CC_LE,
  output logic        REG_WE,
  output logic        MAR_SEL,
  output logic        PC_SEL,
  output logic [3:0]  ALU_CONTROL,
  output logic        IS_IMMEDIATE,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic        ILLEGAL_OP,
  output logic        MEM_ERR
);

  localparam int unsigned WaitW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  // StFAddr=F_ADDR, StFMem=F_MEM, StFIr=F_IR, StMAddr=M_ADDR, StMMem=M_MEM, StMWb=M_WB
  typedef enum logic [3:0] {
    StFAddr,
    StFMem,
    StFIr,
    StDecode,
    StExec,
    StMAddr,
    StMMem,
    StMWb,
    StBranch
  } state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q;
  logic               illegal_q;
  logic               mem_err_q;

  logic [3:0]         opcode;
  logic               is_st;
  logic               ext_legal;
  logic               mem_state;
  logic               timeout;
  logic               illegal_d;
  logic               br_taken;
  logic [3:0]         alu_code;

  assign opcode    = IR[15:12];
  assign is_st     = (opcode == 4'b0011);
  assign mem_state = (state_q == StFMem) || (state_q == StMMem);
  assign br_taken  = |(IR[11:9] & NZP);

  // The last permitted waiting cycle; MEM_RDY in that cycle still completes.
  assign timeout   = mem_state && !MEM_RDY && (wait_q == WaitW'(WAIT_MAX - 1));

`ifdef LC3_MUL_SHIFT_EN
  assign ext_legal = (IR[4:3] != 2'b11);
`else
  assign ext_legal = 1'b0;
`endif

  // Bits not consumed by any decode path.
  logic unused_ir;
  assign unused_ir = ^{IR[8:6], IR[4:3], IR[2:0]};

  // ALU opcode for the instruction in IR; only presented on ALU_CONTROL in EXEC.
  always_comb begin
    alu_code = 4'b0000;
    case (opcode)
      4'b0101: alu_code = 4'b0001;
      4'b1001: alu_code = 4'b0100;
`ifdef LC3_MUL_SHIFT_EN
      4'b1011: begin
        case (IR[4:3])
          2'b00:   alu_code = 4'b0101;
          2'b10:   alu_code = 4'b0110;
          2'b01:   alu_code = 4'b0111;
          default: alu_code = 4'b0000;
        endcase
      end
`endif
      default: alu_code = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFAddr: state_d = StFMem;
      StFMem: begin
        if (MEM_RDY) begin
          state_d = StFIr;
        end else if (timeout) begin
          state_d = StFAddr;
        end
      end
      StFIr: state_d = StDecode;
      StDecode: begin
        case (opcode)
          4'b0001, 4'b0101, 4'b1001: state_d = StExec;
          4'b1011:                   state_d = ext_legal ? StExec : StFAddr;
          4'b0010, 4'b0011:          state_d = StMAddr;
          4'b0000:                   state_d = StBranch;
          default:                   state_d = StFAddr;
        endcase
      end
      StExec:  state_d = StFAddr;
      StMAddr: state_d = StMMem;
      StMMem: begin
        if (MEM_RDY) begin
          state_d = is_st ? StFAddr : StMWb;
        end else if (timeout) begin
          state_d = StFAddr;
        end
      end
      StMWb:    state_d = StFAddr;
      StBranch: state_d = StFAddr;
      default:  state_d = StFAddr;
    endcase
  end

  // Any DECODE exit straight back to fetch means the opcode was not accepted.
  assign illegal_d = (state_q == StDecode) && (state_d == StFAddr);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= StFAddr;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      mem_err_q <= timeout;
      if (state_d != state_q) begin
        wait_q <= '0;
      end else if (mem_state && !MEM_RDY) begin
        wait_q <= wait_q + 1'b1;
      end
    end
  end

  always_comb begin
    MAR_LE       = 1'b0;
    MDR_LE       = 1'b0;
    PC_LE        = 1'b0;
    IR_LE        = 1'b0;
    CC_LE        = 1'b0;
    REG_WE       = 1'b0;
    MAR_SEL      = 1'b0;
    PC_SEL       = 1'b0;
    ALU_CONTROL  = 4'b0000;
    IS_IMMEDIATE = 1'b0;
    MEM_REQ      = 1'b0;
    MEM_WE       = 1'b0;
    unique case (state_q)
      StFAddr: begin
        MAR_LE = 1'b1;
        PC_LE  = 1'b1;
      end
      StFMem: begin
        MEM_REQ = 1'b1;
        MDR_LE  = MEM_RDY;
      end
      StFIr: IR_LE = 1'b1;
      StExec: begin
        REG_WE       = 1'b1;
        CC_LE        = 1'b1;
        ALU_CONTROL  = alu_code;
        IS_IMMEDIATE = ((opcode == 4'b0001) || (opcode == 4'b0101)) && IR[5];
      end
      StMAddr: begin
        MAR_LE  = 1'b1;
        MAR_SEL = 1'b1;
        MDR_LE  = is_st;
      end
      StMMem: begin
        MEM_REQ = 1'b1;
        MEM_WE  = is_st;
        MDR_LE  = MEM_RDY && !is_st;
      end
      StMWb: begin
        REG_WE = 1'b1;
        CC_LE  = 1'b1;
      end
      StBranch: begin
        PC_LE  = br_taken;
        PC_SEL = br_taken;
      end
      default: ;
    endcase
    // Hold every enable inactive while reset is asserted.
    if (!RST_N) begin
      MAR_LE       = 1'b0;
      MDR_LE       = 1'b0;
      PC_LE        = 1'b0;
      IR_LE        = 1'b0;
      CC_LE        = 1'b0;
      REG_WE       = 1'b0;
      MAR_SEL      = 1'b0;
      PC_SEL       = 1'b0;
      ALU_CONTROL  = 4'b0000;
      IS_IMMEDIATE = 1'b0;
      MEM_REQ      = 1'b0;
      MEM_WE       = 1'b0;
    end
  end

  assign ILLEGAL_OP = illegal_q;
  assign MEM_ERR    = mem_err_q;

endmodule

// File: doc/lc3_sequencer.md
LC3_SEQUENCER -- requirements
Module: lc3_sequencer

Interface
REQ-001 The block SHALL have one parameter: WAIT_MAX, default 15, the maximum number of cycles to wait for MEM_RDY before aborting an access.
REQ-002 CLK  in  1  single clock; all state changes on the rising edge.
REQ-003 RST_N  in  1  reset: synchronous, active-low.
REQ-004 IR  in  16  current instruction register contents from the datapath.
REQ-005 NZP  in  3  datapath condition codes {N,Z,P}.
REQ-006 MEM_RDY  in  1  memory access complete for the current cycle.
REQ-007 MAR_LE, MDR_LE, PC_LE, IR_LE, CC_LE, REG_WE  out  1 each  datapath load enables, each asserted for exactly one cycle per use.
REQ-008 MAR_SEL  out  1  MAR source: 0 = PC, 1 = effective address (PC + sext(IR[8:0])).
REQ-009 PC_SEL  out  1  PC source: 0 = PC+1, 1 = branch target.
REQ-010 ALU_CONTROL  out  4  ALU operation code; IS_IMMEDIATE  out  1  selects sext(IR[4:0]) as the ALU B operand.
REQ-011 MEM_REQ, MEM_WE  out  1 each  memory request and write qualifier.
REQ-012 ILLEGAL_OP, MEM_ERR  out  1 each  one-cycle error pulses.

Function
REQ-013 States SHALL be: F_ADDR, F_MEM, F_IR, DECODE, EXEC, M_ADDR, M_MEM, M_WB, BRANCH.
REQ-014 F_ADDR SHALL assert MAR_LE with MAR_SEL=0, plus PC_LE with PC_SEL=0, then go to F_MEM.
REQ-015 F_MEM SHALL hold MEM_REQ=1 and MEM_WE=0, and SHALL assert MDR_LE in the cycle MEM_RDY=1, then go to F_IR; while MEM_RDY=0 it SHALL stay in F_MEM.
REQ-016 F_IR SHALL assert IR_LE, then go to DECODE.
REQ-017 DECODE SHALL route on IR[15:12]:
- 0001, 0101, 1001, 1011 go to EXEC.
- 0010 (LD) and 0011 (ST) go to M_ADDR.
- 0000 (BR) goes to BRANCH.
- Any other opcode SHALL pulse ILLEGAL_OP and go to F_ADDR.
REQ-018 EXEC SHALL assert REG_WE and CC_LE for one cycle, then go to F_ADDR.
REQ-019 ALU_CONTROL SHALL be driven combinationally from IR while in EXEC:
- ADD = 0000; AND = 0001; NOT = 0100.
- Opcode 1011 with IR[4:3] = 00 (MUL) = 0101; 10 (SL) = 0110; 01 (SR) = 0111.
- 1011 with IR[4:3] = 11 SHALL pulse ILLEGAL_OP with no REG_WE.
- In all other states ALU_CONTROL SHALL be 0000.
REQ-020 IS_IMMEDIATE SHALL equal IR[5] in EXEC for ADD/AND, and 0 otherwise.
REQ-021 M_ADDR SHALL assert MAR_LE with MAR_SEL=1; for ST it SHALL also assert MDR_LE (register data). It then goes to M_MEM.
REQ-022 M_MEM SHALL hold MEM_REQ=1, with MEM_WE=1 for ST only, until MEM_RDY.
- LD then goes to M_WB (MDR_LE pulsed on the MEM_RDY cycle).
- ST then goes to F_ADDR.
REQ-023 M_WB SHALL assert REG_WE and CC_LE, then go to F_ADDR.
REQ-024 BRANCH SHALL assert PC_LE with PC_SEL=1 when (IR[11:9] & NZP) != 0, otherwise no PC_LE; it then goes to F_ADDR.
REQ-025 A wait counter SHALL count cycles spent in F_MEM/M_MEM with MEM_RDY=0.
- On reaching WAIT_MAX it SHALL drop MEM_REQ, pulse MEM_ERR, go to F_ADDR, and perform no MDR_LE/REG_WE.
- The counter SHALL clear on every state entry.
REQ-026 MEM_RDY arriving in the same cycle MEM_REQ first asserts SHALL complete the access; MEM_RDY outside F_MEM/M_MEM SHALL be ignored.
REQ-027 Latency SHALL be 5 cycles for ALU ops and BR, and 7 (LD) / 6 (ST) for memory ops, when MEM_RDY returns immediately.

Reset
REQ-028 While RST_N=0 at a rising edge, the state SHALL become F_ADDR, the wait counter 0, and all registered pulse outputs 0.
REQ-029 Reset asserted mid-access SHALL drop MEM_REQ/MEM_WE in the cycle after the edge.
REQ-030 The first cycle after reset release SHALL be F_ADDR.

Configuration
REQ-031 Macro LC3_MUL_SHIFT_EN SHALL control opcode 1011.
- Defined: 1011 is decoded per REQ-019.
- Undefined: 1011 SHALL be treated as illegal per REQ-017, and ALU codes 0101–0111 SHALL never be produced.

Verification
REQ-032 Reset, then MEM_RDY held 1 with fetch data 16'h1262 (ADD R1,R1,#2) -> EXEC in cycle 4, ALU_CONTROL=0000, IS_IMMEDIATE=1, REG_WE one cycle, back in F_ADDR in cycle 5.
REQ-033 IR=16'h0A05 (BRnp) with NZP=010 -> no PC_LE in BRANCH; with NZP=100 -> PC_LE=1, PC_SEL=1.
REQ-034 ST IR=16'h3203 with MEM_RDY delayed 3 cycles -> MEM_REQ=1, MEM_WE=1 for 4 cycles, then F_ADDR, no REG_WE.
REQ-035 MEM_RDY held 0 in F_MEM, WAIT_MAX=15 -> MEM_ERR pulse after 15 cycles, MEM_REQ low, no IR_LE.
REQ-036 IR=16'hB018 with LC3_MUL_SHIFT_EN undefined -> ILLEGAL_OP pulse, no REG_WE; with the macro defined, B018 -> ILLEGAL_OP pulse and B010 (SL) -> ALU_CONTROL=0110.
REQ-037 RST_N=0 during M_MEM -> MEM_REQ=0 next cycle, state F_ADDR after release.
